picosoc_bus_arbiter: RTL
========================

// Module: picosoc_bus_arbiter
// PURPOSE
//  Two-master arbiter for the picorv32 native memory bus (valid/ready/addr/wdata/wstrb/rdata).
//  Shares one downstream bus (RAM, spimemio, UART regs, iomem decode) between the CPU (m0) and a
//  second requester such as a DMA or debug master (m1). Round-robin grant, one transaction per grant.
//  Per-transaction watchdog completes hung accesses so a dead slave cannot stall the SoC.
// PARAMETERS
//  TIMEOUT_CYCLES  255           BUSY cycles before forced completion; 0 disables the watchdog
//  TIMEOUT_RDATA   32'h0000_0000 rdata returned to the master on a forced completion
// PORTS
//  clk          in   1   system clock
//  resetn       in   1   synchronous reset, active low
//  m0_valid     in   1   master 0 request; held with addr/wdata/wstrb/instr until m0_ready
//  m0_instr     in   1   master 0 instruction-fetch flag
//  m0_addr      in   32  master 0 byte address
//  m0_wdata     in   32  master 0 write data
//  m0_wstrb     in   4   master 0 byte strobes; 0 = read
//  m0_ready     out  1   master 0 completion strobe, one cycle
//  m0_rdata     out  32  master 0 read data, valid with m0_ready
//  m1_*         --   --  master 1, same set and meaning as m0_*
//  s_valid      out  1   downstream request
//  s_instr      out  1   downstream instruction flag
//  s_addr       out  32  downstream address
//  s_wdata      out  32  downstream write data
//  s_wstrb      out  4   downstream byte strobes
//  s_ready      in   1   downstream completion
//  s_rdata      in   32  downstream read data
//  grant        out  2   one-hot current owner {m1,m0}; 2'b00 when idle
//  timeout_irq  out  1   one-cycle pulse on forced completion (wire to an irq bit, e.g. irq[3])
// BEHAVIOUR
//  Reset (resetn=0 at posedge): state=IDLE, grant=0, s_valid=0, m*_ready=0, timeout_irq=0,
//   watchdog=0, last=m1 (so m0 wins the first tie). Rdata outputs are don't-care while ready=0.
//  IDLE: if any m*_valid, register grant: sole requester wins; on a tie, the master != last wins.
//   -> BUSY. No ready is ever asserted in IDLE.
//  BUSY: s_valid = granted m_valid; s_addr/wdata/wstrb/instr mux from the granted master (0 when idle).
//   Granted m_ready = s_ready & s_valid, combinational; m_rdata = s_rdata. Other master ready=0.
//   On s_ready&s_valid: last<=owner, grant<=0 -> IDLE.
//  Latency: request to s_valid = 1 cycle; min 1 IDLE cycle between consecutive grants.
//  Watchdog: counts BUSY cycles from 0. If TIMEOUT_CYCLES!=0 and count reaches TIMEOUT_CYCLES-1 with
//   no s_ready, that cycle: owner m_ready=1, m_rdata=TIMEOUT_RDATA, s_valid=0, timeout_irq=1,
//   last<=owner, -> IDLE. s_ready in the same cycle takes priority (normal completion, no irq).
//  Owner drops m_valid in BUSY (protocol violation / master reset): s_valid=0 that cycle, no ready,
//   last<=owner, -> IDLE.
//  Non-owner requests are held off (ready=0) for the whole BUSY period; no pre-emption.
//  resetn low mid-BUSY: transaction abandoned, outputs at reset values next cycle.
//  Watchdog width = $clog2(TIMEOUT_CYCLES+1), min 1; no wrap: count saturates when disabled.
// STRUCTURE
//  picosoc_bus_defs.vh: state encodings (ST_IDLE, ST_BUSY), master indices, GNT_NONE/GNT_M0/GNT_M1.
//  One sub-module: picosoc_bus_watchdog (clk, resetn, clear, run -> expire); rest is inline FSM + mux.
// TESTING
//  m0 read 0x0000_0010, slave ready 2 cycles after s_valid, rdata 0x1234_5678 -> s_valid 1 cycle
//   after m0_valid, m0_ready one cycle with 0x1234_5678, grant 01->00, m1_ready stays 0.
//  m0,m1 request same cycle after reset -> m0 first, then IDLE, then m1; repeat tie -> m0 again.
//  m0 write 0x0200_0008 wdata 0x41 wstrb 4'b0001 while m1 requests -> s_wstrb=0001, m1 waits,
//   m1 granted 1 cycle after m0_ready.
//  TIMEOUT_CYCLES=8, slave never ready -> 8th BUSY cycle: m0_ready=1, rdata=TIMEOUT_RDATA,
//   timeout_irq pulse, s_valid=0; s_ready on that same cycle instead -> normal data, no irq.
//  resetn low for 1 cycle mid-BUSY -> next cycle s_valid=0, grant=00, all ready 0; tie after -> m0.
//  Owner drops valid in BUSY -> no ready, IDLE next cycle, other master granted next.

Source files
------------

// File: rtl/picosoc_bus_arbiter_pkg.sv
// Shared encodings and helpers for the two-master picorv32 native-bus arbiter.
package picosoc_bus_arbiter_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam logic M0_IDX = 1'b0;
   localparam logic M1_IDX = 1'b1;

   typedef logic [1:0] grant_t;

   localparam grant_t GNT_NONE = 2'b00;
   localparam grant_t GNT_M0   = 2'b01;
   localparam grant_t GNT_M1   = 2'b10;

   typedef struct packed {
      logic        valid;
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } bus_req_t;

   function automatic grant_t grant_of(input logic idx);
      return (idx == M1_IDX) ? GNT_M1 : GNT_M0;
   endfunction

   // A lone requester always wins; on a tie the master that did not go last wins.
   function automatic logic pick_winner(input logic req0, input logic req1, input logic last_owner);
      if (req0 && req1) begin
         return ~last_owner;
      end
      return req1 ? M1_IDX : M0_IDX;
   endfunction

endpackage

// File: rtl/picosoc_bus_arbiter_if.sv
// One picorv32 native memory-bus port: request side plus completion side.
interface picosoc_bus_arbiter_if;

   logic        valid;
   logic        instr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        ready;
   logic [31:0] rdata;

   modport master (
      output valid, instr, addr, wdata, wstrb,
      input  ready, rdata
   );

   modport slave (
      input  valid, instr, addr, wdata, wstrb,
      output ready, rdata
   );

endinterface

// File: rtl/picosoc_bus_arbiter_watchdog.sv
// Per-transaction BUSY-cycle counter; expire marks the last cycle a slave is allowed to take.
module picosoc_bus_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic resetn,
   input  logic clear,
   input  logic run,
   output logic expire
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

   logic [CNT_W-1:0] count;

   // Saturating so a disabled watchdog can sit in a long BUSY period without wrapping.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (run && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expire = (TIMEOUT_CYCLES != 0) && run && (count == CNT_W'(LIMIT));

endmodule

// File: rtl/picosoc_bus_arbiter.sv
// Round-robin arbiter sharing one downstream picorv32 bus between two masters,
// one transaction per grant, with a watchdog that force-completes hung accesses.
module picosoc_bus_arbiter
   import picosoc_bus_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] TIMEOUT_RDATA  = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  resetn,
   picosoc_bus_arbiter_if.slave  m0,
   picosoc_bus_arbiter_if.slave  m1,
   picosoc_bus_arbiter_if.master s,
   output logic [1:0]            grant,
   output logic                  timeout_irq
);

   logic [0:0]  state;
   grant_t      grant_q;
   logic        last;
   bus_req_t    req0;
   bus_req_t    req1;
   bus_req_t    owner_req;
   logic        owner;
   logic        busy;
   logic        expire;
   logic        done_normal;
   logic        forced;
   logic        dropped;
   logic        ack;
   logic [31:0] rdata_out;

   always_comb begin
      req0 = '{valid: m0.valid, instr: m0.instr, addr: m0.addr, wdata: m0.wdata, wstrb: m0.wstrb};
      req1 = '{valid: m1.valid, instr: m1.instr, addr: m1.addr, wdata: m1.wdata, wstrb: m1.wstrb};
      owner_req = '0;
      case (grant_q)
         GNT_M0:  owner_req = req0;
         GNT_M1:  owner_req = req1;
         default: owner_req = '0;
      endcase
   end

   assign owner = grant_q[1];
   assign busy  = (state == ST_BUSY);

   // A slave ready in the expiry cycle still wins, so s_valid stays up when s_ready is present.
   assign s.valid = busy & owner_req.valid & (~expire | s.ready);
   assign s.instr = owner_req.instr;
   assign s.addr  = owner_req.addr;
   assign s.wdata = owner_req.wdata;
   assign s.wstrb = owner_req.wstrb;

   assign done_normal = s.valid & s.ready;
   assign forced      = busy & owner_req.valid & expire & ~s.ready;
   assign dropped     = busy & ~owner_req.valid;
   assign ack         = done_normal | forced;
   assign rdata_out   = forced ? TIMEOUT_RDATA : s.rdata;

   assign m0.ready    = ack & (grant_q == GNT_M0);
   assign m1.ready    = ack & (grant_q == GNT_M1);
   assign m0.rdata    = rdata_out;
   assign m1.rdata    = rdata_out;
   assign timeout_irq = forced;
   assign grant       = grant_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state   <= ST_IDLE;
         grant_q <= GNT_NONE;
         last    <= M1_IDX;
      end else if (state == ST_IDLE) begin
         if (m0.valid || m1.valid) begin
            grant_q <= grant_of(pick_winner(m0.valid, m1.valid, last));
            state   <= ST_BUSY;
         end
      end else if (ack || dropped) begin
         last    <= owner;
         grant_q <= GNT_NONE;
         state   <= ST_IDLE;
      end
   end

   picosoc_bus_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .resetn (resetn),
      .clear  (~busy),
      .run    (busy),
      .expire (expire)
   );

endmodule
